// File: rtl/dense_pkg.sv
// Shared types and helpers for the dense layer engine.
// Imported by the top and the result RAM.
package dense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    WRITE
  } state_t;

  localparam int DW_D       = 18;
  localparam int WW_D       = 9;
  localparam int IN_LANES_D = 2;
  localparam int OUT_CH_D   = 4;
  localparam int STEPS_D    = 10;
  localparam int DEPTH_D    = 121;
  localparam int SHIFT_D    = 0;

  localparam logic [1:0] SR_PASS = 2'b00;
  localparam logic [1:0] SR_ZERO = 2'b01;
  localparam logic [1:0] SR_HIGH = 2'b10;

  function automatic int acc_w(
    input int dw,
    input int ww,
    input int steps,
    input int lanes
  );
    return dw + ww + $clog2(steps * lanes) + 1;
  endfunction

  // Classifies v for ReLU plus clamp to a dw-bit positive range.
  function automatic logic [1:0] sat_relu(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] mx;
    mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
    if (v <= 64'sd0)
      return SR_ZERO;
    else if (v > mx)
      return SR_HIGH;
    else
      return SR_PASS;
  endfunction

endpackage

// File: rtl/dense_result_ram.sv
// Result store: one write port, one registered read port.
// Read-during-write to the same address returns the old word.
module dense_result_ram
  import dense_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int W     = OUT_CH_D * DW_D,
  parameter int AW    = $clog2(DEPTH_D + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rd
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd <= '0;
    else
      rd <= mem[ra];
  end

endmodule

// File: rtl/dense_layer_pipe.sv
// Fully-connected layer: MAC over STEPS beats, bias, shift,
// ReLU, saturate, and store one word per group.
module dense_layer_pipe
  import dense_pkg::*;
#(
  parameter int DW       = DW_D,
  parameter int WW       = WW_D,
  parameter int IN_LANES = IN_LANES_D,
  parameter int OUT_CH   = OUT_CH_D,
  parameter int STEPS    = STEPS_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int SHIFT    = SHIFT_D
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            strt,
  input  logic                            din_vld,
  input  logic [IN_LANES*DW-1:0]          din,
  output logic                            din_rdy,
  output logic [$clog2(STEPS)-1:0]        w_addr,
  input  logic [OUT_CH*IN_LANES*WW-1:0]   w_data,
  input  logic [OUT_CH*WW-1:0]            bias,
  input  logic [$clog2(DEPTH+1)-1:0]      rd_addr,
  output logic [OUT_CH*DW-1:0]            rd_data,
  input  logic                            tx_done,
  output logic                            bsy,
  output logic                            full,
  output logic [7:0]                      sat_cnt
);

  localparam int ACC_W = acc_w(DW, WW, STEPS, IN_LANES);
  localparam int SW    = $clog2(STEPS);
  localparam int AW    = $clog2(DEPTH + 1);
  localparam int RW    = OUT_CH * DW;

  state_t             state, state_nxt;
  logic [SW-1:0]      step;
  logic [AW-1:0]      wr_addr;
  logic               fire, start, last, we;
  logic [RW-1:0]      wdata;
  logic [OUT_CH-1:0]  hi;
  logic [15:0]        sat_sum;

  assign full    = wr_addr == AW'(DEPTH);
  assign fire    = din_vld && din_rdy;
  assign start   = (state == IDLE) && strt && !full && !tx_done;
  assign last    = step == SW'(STEPS - 1);
  assign we      = (state == WRITE) && !tx_done;
  assign w_addr  = step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (fire && last) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (tx_done)
      state_nxt = IDLE;
  end

  always_comb begin
    bsy     = 1'b0;
    din_rdy = 1'b0;
    unique case (state)
      IDLE: ;
      ACCUM: begin
        bsy     = 1'b1;
        din_rdy = 1'b1;
      end
      WRITE:   bsy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      step <= '0;
    else if (tx_done || start)
      step <= '0;
    else if (state == ACCUM && fire)
      step <= last ? '0 : step + SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wr_addr <= '0;
    else if (tx_done)
      wr_addr <= '0;
    else if (we)
      wr_addr <= wr_addr + AW'(1);
  end

  always_comb begin
    sat_sum = {8'd0, sat_cnt};
    for (int i = 0; i < OUT_CH; i++)
      sat_sum = sat_sum + 16'(hi[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (tx_done)
      sat_cnt <= '0;
    else if (we)
      sat_cnt <= (sat_sum > 16'd255) ? 8'd255 : sat_sum[7:0];
  end

  for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
    logic signed [ACC_W-1:0] acc, sum, v;
    logic [1:0]              sel;

    always_comb begin
      sum = acc;
      for (int l = 0; l < IN_LANES; l++)
        sum = sum + ACC_W'(
          $signed(din[l*DW +: DW]) *
          $signed(w_data[(c*IN_LANES+l)*WW +: WW]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        acc <= '0;
      else if (start)
        acc <= '0;
      else if (state == ACCUM && fire)
        acc <= sum;
    end

    assign v   = (acc + ACC_W'($signed(bias[c*WW +: WW])))
                 >>> SHIFT;
    assign sel = sat_relu(64'(v), DW);
    assign hi[c] = sel == SR_HIGH;

    always_comb begin
      unique case (1'b1)
        sel == SR_ZERO: wdata[c*DW +: DW] = '0;
        sel == SR_HIGH: wdata[c*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
        default:        wdata[c*DW +: DW] = v[DW-1:0];
      endcase
    end
  end

  dense_result_ram #(
    .DEPTH (DEPTH),
    .W     (RW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wr_addr),
    .wd    (wdata),
    .ra    (rd_addr),
    .rd    (rd_data)
  );

endmodule
